// File: rtl/burst_memory_arbiter.sv
// rtl/burst_memory_arbiter.sv - round-robin shared block memory with burst read/write beats
//
// Ports:
//   clk, rst_n       single rising-edge clock, asynchronous active-low reset
//   req[ch]          0/3 none, 1 read, 2 write (held until ack)
//   address[ch]      block address, latched at ack
//   w_data[ch]       write beat, consumed while w_ready[ch] is high
//   ack[ch]          one-cycle grant pulse, combinational in the IDLE cycle
//   w_ready[ch]      write beat consumed this cycle
//   r_valid[ch]      r_data[ch] carries a read beat this cycle
//   r_last[ch]       final beat of the burst (read or write)
//   r_data[ch]       read beat, zero when r_valid[ch] is low
module burst_memory_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_SIZE  = 128,
    parameter int TRANS_SIZE  = 32,
    parameter int LATENCY     = 0,
    parameter bit PARTITIONED = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CH-1:0][1:0]              req,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   address,
    input  logic [NUM_CH-1:0][TRANS_SIZE-1:0]   w_data,
    output logic [NUM_CH-1:0]                   ack,
    output logic [NUM_CH-1:0]                   w_ready,
    output logic [NUM_CH-1:0]                   r_valid,
    output logic [NUM_CH-1:0]                   r_last,
    output logic [NUM_CH-1:0][TRANS_SIZE-1:0]   r_data
);
    localparam logic [1:0] REQ_READ  = 2'd1;
    localparam logic [1:0] REQ_WRITE = 2'd2;

    localparam int BEATS = BLOCK_SIZE / TRANS_SIZE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW    = (PARTITIONED && NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int IW    = ADDR_WIDTH + PW;
    localparam int DEPTH = 1 << IW;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [3:0]    WAIT_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    generate
        if (NUM_CH < 1 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
            BEATS * TRANS_SIZE != BLOCK_SIZE) begin : g_bad_geometry
            $error("burst_memory_arbiter: illegal NUM_CH/BLOCK_SIZE/TRANS_SIZE");
        end
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("burst_memory_arbiter: LATENCY out of range 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD_BURST, S_WR_BURST} state_t;

    state_t                  state, state_n;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           last_grant;
    logic                    op_wr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BW-1:0]           beat;
    logic [3:0]              wait_cnt;

    logic [NUM_CH-1:0]       req_ok;
    logic                    any_req;
    logic [GW-1:0]           pick;
    logic [IW-1:0]           idx_q;
    logic [BLOCK_SIZE-1:0]   rd_block;

    logic [BLOCK_SIZE-1:0]   mem [DEPTH];

    generate
        if (PW > 0) begin : g_part
            assign idx_q = {grant[PW-1:0], addr_q};
        end else begin : g_shared
            assign idx_q = addr_q;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_ok[i] = (req[i] == REQ_READ) || (req[i] == REQ_WRITE);
        end
    end

    // Walk from lowest priority (last_grant itself) to highest (last_grant+1)
    // so the last hit assigned is the round-robin winner.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req_ok[(int'(last_grant) + i) % NUM_CH]) begin
                any_req = 1'b1;
                pick    = GW'((int'(last_grant) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (LATENCY > 0)                 state_n = S_WAIT;
                    else if (req[pick] == REQ_WRITE) state_n = S_WR_BURST;
                    else                             state_n = S_RD_BURST;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_n = op_wr ? S_WR_BURST : S_RD_BURST;
            end
            S_RD_BURST, S_WR_BURST: begin
                if (beat == BEAT_LAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_CH - 1);
            op_wr      <= 1'b0;
            addr_q     <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        op_wr      <= (req[pick] == REQ_WRITE);
                        addr_q     <= address[pick];
                    end
                end
                S_WAIT: wait_cnt <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
                // BEATS is a power of two, so the counter wraps to 0 after the last beat.
                S_RD_BURST, S_WR_BURST: beat <= beat + 1'b1;
                default: ;
            endcase
        end
    end

    // Contents are deliberately not reset; the async reset forces IDLE so an
    // aborted burst stops writing immediately.
    always_ff @(posedge clk) begin
        if (state == S_WR_BURST) begin
            mem[idx_q][int'(beat) * TRANS_SIZE +: TRANS_SIZE] <= w_data[grant];
        end
    end

    assign rd_block = mem[idx_q];

    always_comb begin
        ack     = '0;
        w_ready = '0;
        r_valid = '0;
        r_last  = '0;
        r_data  = '0;
        if (rst_n) begin
            if (state == S_IDLE && any_req) ack[pick] = 1'b1;
            if (state == S_RD_BURST) begin
                r_valid[grant] = 1'b1;
                r_data[grant]  = rd_block[int'(beat) * TRANS_SIZE +: TRANS_SIZE];
                r_last[grant]  = (beat == BEAT_LAST);
            end
            if (state == S_WR_BURST) begin
                w_ready[grant] = 1'b1;
                r_last[grant]  = (beat == BEAT_LAST);
            end
        end
    end
endmodule

// File: tb/tb_burst_memory_arbiter.sv
// tb/tb_burst_memory_arbiter.sv - self-checking bench for burst_memory_arbiter
module tb_burst_memory_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // inst 0: NUM_CH=2, LATENCY=0, partitioned; inst 1: NUM_CH=2, LATENCY=3, shared
    logic [1:0][1:0]  req_x   [2];
    logic [1:0][7:0]  addr_x  [2];
    logic [1:0][31:0] wd_x    [2];
    logic [1:0]       ack_x   [2];
    logic [1:0]       wr_x    [2];
    logic [1:0]       rv_x    [2];
    logic [1:0]       rl_x    [2];
    logic [1:0][31:0] rd_x    [2];

    // round-robin instance: NUM_CH=4, LATENCY=0
    logic [3:0][1:0]  req_b;
    logic [3:0][7:0]  addr_b;
    logic [3:0][31:0] wd_b;
    logic [3:0]       ack_b, wr_b, rv_b, rl_b;
    logic [3:0][31:0] rd_b;

    burst_memory_arbiter #(.NUM_CH(2), .ADDR_WIDTH(8), .BLOCK_SIZE(128), .TRANS_SIZE(32),
                           .LATENCY(0), .PARTITIONED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_x[0]), .address(addr_x[0]), .w_data(wd_x[0]),
        .ack(ack_x[0]), .w_ready(wr_x[0]), .r_valid(rv_x[0]), .r_last(rl_x[0]), .r_data(rd_x[0]));

    burst_memory_arbiter #(.NUM_CH(2), .ADDR_WIDTH(8), .BLOCK_SIZE(128), .TRANS_SIZE(32),
                           .LATENCY(3), .PARTITIONED(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_x[1]), .address(addr_x[1]), .w_data(wd_x[1]),
        .ack(ack_x[1]), .w_ready(wr_x[1]), .r_valid(rv_x[1]), .r_last(rl_x[1]), .r_data(rd_x[1]));

    burst_memory_arbiter #(.NUM_CH(4), .ADDR_WIDTH(8), .BLOCK_SIZE(128), .TRANS_SIZE(32),
                           .LATENCY(0), .PARTITIONED(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .address(addr_b), .w_data(wd_b),
        .ack(ack_b), .w_ready(wr_b), .r_valid(rv_b), .r_last(rl_b), .r_data(rd_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          ch;
        logic [31:0] data;
        bit          last;
    } sb_t;

    sb_t qa[$];
    sb_t qc[$];
    sb_t mon_e;

    task automatic push_exp(input int inst, input sb_t e);
        if (inst == 0) qa.push_back(e);
        else           qc.push_back(e);
    endtask

    function automatic int q_size(input int inst);
        return (inst == 0) ? qa.size() : qc.size();
    endfunction

    // Scoreboard: every read beat seen on the bus must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 2; c++) begin
                    if (rv_x[i][c]) begin
                        chk("sb_not_empty", q_size(i) != 0, 1);
                        if (q_size(i) != 0) begin
                            if (i == 0) mon_e = qa.pop_front();
                            else        mon_e = qc.pop_front();
                            chk("sb_ch", c, mon_e.ch);
                            chk("sb_data", rd_x[i][c], mon_e.data);
                            chk("sb_last", rl_x[i][c], mon_e.last);
                        end
                    end else begin
                        chk("rdata_idle_zero", rd_x[i][c], 0);
                    end
                end
            end
        end
    end

    task automatic txn(input int inst, input int ch, input bit wr,
                       input logic [7:0] a, input logic [127:0] blk);
        int n;
        int lat;
        lat = (inst == 0) ? 0 : 3;
        req_x[inst][ch]  = wr ? 2'd2 : 2'd1;
        addr_x[inst][ch] = a;
        if (!wr) begin
            for (int k = 0; k < 4; k++) push_exp(inst, '{ch, blk[k*32 +: 32], k == 3});
        end
        n = 0;
        @(negedge clk);
        while (!ack_x[inst][ch] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack", ack_x[inst][ch], 1);
        chk("ack_immediate", n, 0);
        @(posedge clk);
        #1;
        req_x[inst][ch]  = 2'd0;
        addr_x[inst][ch] = 8'hEE;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("wait_quiet", {rv_x[inst], wr_x[inst], rl_x[inst]}, 0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            if (wr) wd_x[inst][ch] = blk[k*32 +: 32];
            @(negedge clk);
            if (wr) chk("w_ready", wr_x[inst][ch], 1);
            else    chk("r_valid", rv_x[inst][ch], 1);
            chk("r_last", rl_x[inst][ch], k == 3);
            chk("other_ch_quiet", {wr_x[inst][1-ch], rv_x[inst][1-ch]}, 0);
            @(posedge clk);
            #1;
        end
        if (!wr) chk("sb_drained", q_size(inst), 0);
    endtask

    typedef struct {
        int             inst;
        int             ch;
        bit             wr;
        logic [7:0]     addr;
        logic [127:0]   blk;
    } vec_t;

    localparam logic [127:0] BLK_ABCD = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] BLK_1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] BLK_P    = {32'h50000003, 32'h50000002, 32'h50000001, 32'h50000000};
    localparam logic [127:0] BLK_Q    = {32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h00000001};
    localparam logic [127:0] BLK_R    = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    localparam logic [127:0] BLK_S    = {32'h0BADF00D, 32'hCAFEBABE, 32'hDEADBEEF, 32'hFEEDFACE};
    localparam logic [127:0] BLK_OLD  = {32'h0D000003, 32'h0D000002, 32'h0D000001, 32'h0D000000};
    localparam logic [127:0] BLK_NEW  = {32'h0E000003, 32'h0E000002, 32'h0E000001, 32'h0E000000};

    vec_t vt[12];
    int   ack_cyc[5];
    logic [3:0] ack_who[5];
    int   n_acks;
    logic [3:0] exp_who;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{0, 0, 1'b1, 8'h05, BLK_ABCD};
        vt[1]  = '{0, 0, 1'b0, 8'h05, BLK_ABCD};
        vt[2]  = '{0, 0, 1'b1, 8'h12, BLK_P};
        vt[3]  = '{0, 1, 1'b1, 8'h12, BLK_1234};
        vt[4]  = '{0, 1, 1'b0, 8'h12, BLK_1234};
        vt[5]  = '{0, 0, 1'b0, 8'h12, BLK_P};
        vt[6]  = '{0, 1, 1'b1, 8'hFF, BLK_Q};
        vt[7]  = '{0, 1, 1'b0, 8'hFF, BLK_Q};
        vt[8]  = '{1, 0, 1'b1, 8'h07, BLK_R};
        vt[9]  = '{1, 1, 1'b0, 8'h07, BLK_R};
        vt[10] = '{1, 1, 1'b1, 8'h07, BLK_S};
        vt[11] = '{1, 0, 1'b0, 8'h07, BLK_S};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_x[i] = '0; addr_x[i] = '0; wd_x[i] = '0;
        end
        req_x[0] = {2'd1, 2'd2};
        req_b  = {4{2'd1}};
        addr_b = '0;
        wd_b   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", {ack_x[0], wr_x[0], rv_x[0], rl_x[0], rd_x[0]}, 0);
        chk("rst_outs_c", {ack_x[1], wr_x[1], rv_x[1], rl_x[1], rd_x[1]}, 0);
        chk("rst_outs_b", {ack_b, wr_b, rv_b, rl_b, rd_b}, 0);
        req_x[0] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin: all four channels read continuously from reset.
        n_acks = 0;
        for (int t = 0; t < 40 && n_acks < 5; t++) begin
            @(negedge clk);
            if (ack_b != 0) begin
                ack_who[n_acks] = ack_b;
                ack_cyc[n_acks] = cyc;
                n_acks++;
            end
        end
        chk("rr_ack_count", n_acks, 5);
        for (int i = 0; i < n_acks; i++) begin
            exp_who = 4'b0001 << (i % 4);
            chk("rr_order", ack_who[i], exp_who);
            if (i > 0) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 5);
        end
        @(posedge clk);
        #1 req_b = '0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            txn(vt[i].inst, vt[i].ch, vt[i].wr, vt[i].addr, vt[i].blk);
        end

        // Code 3 is no request on either instance.
        req_x[0] = {2'd3, 2'd3};
        req_x[1] = {2'd3, 2'd3};
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("req3_no_ack", {ack_x[0], ack_x[1]}, 0);
        end
        @(posedge clk);
        #1;
        req_x[0] = '0;
        req_x[1] = '0;

        // Reset in the middle of a write burst after two beats.
        txn(0, 0, 1'b1, 8'h20, BLK_OLD);
        req_x[0][0]  = 2'd2;
        addr_x[0][0] = 8'h20;
        @(negedge clk);
        chk("midrst_ack", ack_x[0][0], 1);
        @(posedge clk);
        #1;
        req_x[0][0] = 2'd0;
        wd_x[0][0]  = BLK_NEW[31:0];
        @(posedge clk);
        #1 wd_x[0][0] = BLK_NEW[63:32];
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_outs_now", {ack_x[0], wr_x[0], rv_x[0], rl_x[0], rd_x[0]}, 0);
        @(negedge clk);
        chk("midrst_outs", {ack_x[0], wr_x[0], rv_x[0], rl_x[0], rd_x[0]}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        txn(0, 0, 1'b0, 8'h20, {BLK_OLD[127:64], BLK_NEW[63:0]});

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
